// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with plain overwrite, MTHI/MTLO writes and a two-stage
// carry-split multiply-accumulate (add or subtract) into {HI,LO}.
module hilo_acc_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mult_finish,
  input  logic [1:0]   mult_op,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wr_data,
  input  logic         flush,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         acc_busy,
  output logic         acc_done
);

  // Two's-complement negation over the full 2W-bit accumulator width.
  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + {{(2*W-1){1'b0}}, 1'b1};
  endfunction

  // Low-half add that keeps the carry out as the top bit.
  function automatic logic [W:0] add_lo(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // High-half add with incoming carry, wrapping at 2^W.
  function automatic logic [W-1:0] add_hi(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
    return a + b + {{(W-1){1'b0}}, c};
  endfunction

  logic           vld_p1;
  logic           vld_p2;
  logic [2*W-1:0] b_p1;
  logic [W-1:0]   bhi_p2;
  logic           carry_p2;

  logic           busy;
  logic           fin_ok;
  logic           launch_p0;
  logic           ovw_p0;
  logic           sub_p0;
  logic [W:0]     sum_lo_p1;
  logic           commit_p1;

  assign busy      = vld_p1 | vld_p2;
  // mult_finish is ignored while an accumulate is in flight.
  assign fin_ok    = mult_finish & ~busy;
  assign launch_p0 = fin_ok & (mult_op == 2'b01 || mult_op == 2'b10);
  assign ovw_p0    = fin_ok & (mult_op == 2'b00 || mult_op == 2'b11);
  assign sub_p0    = (mult_op == 2'b10);
  assign sum_lo_p1 = add_lo(lo, b_p1[W-1:0]);
  assign commit_p1 = vld_p1 & ~flush;

  assign acc_busy = busy;
  assign acc_done = vld_p2;

  // Stage 0 -> 1: capture the signed-adjusted operand at launch.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= launch_p0;
  end

  always_ff @(posedge clk) begin
    if (launch_p0)
      b_p1 <= sub_p0 ? neg_2w({mult_hi, mult_lo}) : {mult_hi, mult_lo};
  end

  // Stage 1 -> 2: commit LO, forward carry and the high operand half.
  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= commit_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      carry_p2 <= sum_lo_p1[W];
      bhi_p2   <= b_p1[2*W-1:W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            lo <= '0;
    else if (commit_p1) lo <= sum_lo_p1[W-1:0];
    else if (ovw_p0)    lo <= mult_lo;
    else if (lo_we)     lo <= wr_data;
  end

  // Stage 2 commit: HI completes regardless of flush.
  always_ff @(posedge clk) begin
    if (rst)         hi <= '0;
    else if (vld_p2) hi <= add_hi(hi, bhi_p2, carry_p2);
    else if (ovw_p0) hi <= mult_hi;
    else if (hi_we)  hi <= wr_data;
  end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Bench for hilo_acc_unit: directed cases plus random traffic against a
// 64-bit {HI,LO} arithmetic reference.
module tb_hilo_acc_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         mult_finish;
  logic [1:0]   mult_op;
  logic [W-1:0] mult_hi;
  logic [W-1:0] mult_lo;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wr_data;
  logic         flush;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         acc_busy;
  logic         acc_done;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] m;  // reference {HI,LO}

  hilo_acc_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .mult_finish(mult_finish), .mult_op(mult_op),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .hi_we(hi_we), .lo_we(lo_we),
    .wr_data(wr_data), .flush(flush), .hi(hi), .lo(lo),
    .acc_busy(acc_busy), .acc_done(acc_done)
  );

  always #5 clk = ~clk;

  // Upstream must not write HI/LO or launch while an accumulate is in flight.
  always @(posedge clk) begin
    if (!rst && acc_busy) begin
      assert (!(mult_finish || hi_we || lo_we))
      else begin
        bad++;
        $error("FAIL protocol: write while busy (fin=%0b hi_we=%0b lo_we=%0b)",
               mult_finish, hi_we, lo_we);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2*W-1:0] ref_v,
                           input logic busy_e, input logic done_e);
    chk({tag, ".hi"},   hi, ref_v[2*W-1:W]);
    chk({tag, ".lo"},   lo, ref_v[W-1:0]);
    chk({tag, ".busy"}, {{(W-1){1'b0}}, acc_busy}, {{(W-1){1'b0}}, busy_e});
    chk({tag, ".done"}, {{(W-1){1'b0}}, acc_done}, {{(W-1){1'b0}}, done_e});
  endtask

  task automatic idle();
    mult_finish = 1'b0; mult_op = 2'b00; mult_hi = '0; mult_lo = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0; flush = 1'b0;
  endtask

  task automatic preset(input logic [W-1:0] h, input logic [W-1:0] l);
    hi_we = 1'b1; wr_data = h; step();
    hi_we = 1'b0; lo_we = 1'b1; wr_data = l; step();
    lo_we = 1'b0;
    m = {h, l};
  endtask

  task automatic overwrite(input string tag, input logic [1:0] op,
                           input logic [2*W-1:0] prod);
    mult_finish = 1'b1; mult_op = op; {mult_hi, mult_lo} = prod;
    step();
    mult_finish = 1'b0;
    m = prod;
    chk_state(tag, m, 1'b0, 1'b0);
  endtask

  // fl_at: 0 no flush, 1 flush in T+1, 2 flush in T+2
  task automatic accum(input string tag, input logic [1:0] op,
                       input logic [2*W-1:0] prod, input int fl_at);
    logic [2*W-1:0] m_new;
    m_new = (op == 2'b01) ? m + prod : m - prod;
    mult_finish = 1'b1; mult_op = op; {mult_hi, mult_lo} = prod;
    step();
    mult_finish = 1'b0; mult_hi = $urandom; mult_lo = $urandom;
    chk_state({tag, ".t1"}, m, 1'b1, 1'b0);
    flush = (fl_at == 1);
    step();
    flush = 1'b0;
    if (fl_at == 1) begin
      chk_state({tag, ".killed"}, m, 1'b0, 1'b0);
      step();
      chk_state({tag, ".after"}, m, 1'b0, 1'b0);
    end else begin
      chk_state({tag, ".t2"}, {m[2*W-1:W], m_new[W-1:0]}, 1'b1, 1'b1);
      flush = (fl_at == 2);
      step();
      flush = 1'b0;
      m = m_new;
      chk_state({tag, ".t3"}, m, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [2*W-1:0] p;
    logic [W-1:0]   d;
    int             k;

    idle();
    rst = 1'b1;
    m = '0;
    repeat (3) step();
    rst = 1'b0;
    chk_state("reset", '0, 1'b0, 1'b0);

    overwrite("ovw00", 2'b00, 64'h12345678_9ABCDEF0);
    hi_we = 1'b1; wr_data = 32'hDEADBEEF;
    overwrite("ovw_vs_mthi", 2'b00, 64'h12345678_9ABCDEF0);
    hi_we = 1'b0;
    lo_we = 1'b1; wr_data = 32'h0BADF00D;
    overwrite("ovw11_vs_mtlo", 2'b11, 64'hCAFEBABE_00C0FFEE);
    lo_we = 1'b0;

    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5A5A5A5A;
    step();
    idle();
    m = {32'h5A5A5A5A, 32'h5A5A5A5A};
    chk_state("mthi_mtlo", m, 1'b0, 1'b0);

    preset(32'h0, 32'hFFFFFFFF);
    accum("add_carry", 2'b01, 64'h1, 0);
    chk("add_carry.hi1", hi, 32'h1);

    preset(32'h1, 32'h0);
    accum("sub_borrow", 2'b10, 64'h1, 0);
    chk("sub_borrow.lo", lo, 32'hFFFFFFFF);

    preset(32'h0, 32'h0);
    accum("sub_wrap", 2'b10, 64'h1, 0);
    chk("sub_wrap.hi", hi, 32'hFFFFFFFF);

    preset(32'h5, 32'h7);
    accum("flush_t1", 2'b01, 64'h1_00000001, 1);

    accum("flush_t2", 2'b01, 64'h1_00000001, 2);
    chk("flush_t2.hi6", hi, 32'h6);

    // Reset arriving while stage 2 is pending abandons the accumulate.
    preset(32'h5, 32'h7);
    mult_finish = 1'b1; mult_op = 2'b01; {mult_hi, mult_lo} = 64'h1_00000001;
    step();
    mult_finish = 1'b0;
    step();
    chk("rst_t2.lo_pre", lo, 32'h8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m = '0;
    chk_state("rst_t2", m, 1'b0, 1'b0);
    repeat (3) step();
    chk_state("rst_t2.later", m, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      p = {$urandom, $urandom};
      d = $urandom;
      case (k)
        0: overwrite("rnd_ovw", ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, p);
        1: begin
          hi_we = $urandom_range(0, 1); lo_we = $urandom_range(0, 1); wr_data = d;
          step();
          if (hi_we) m[2*W-1:W] = d;
          if (lo_we) m[W-1:0] = d;
          hi_we = 1'b0; lo_we = 1'b0;
          chk_state("rnd_mt", m, 1'b0, 1'b0);
        end
        2, 3: accum("rnd_add", 2'b01, p, $urandom_range(0, 2));
        default: accum("rnd_sub", 2'b10, p, $urandom_range(0, 2));
      endcase
      flush = ($urandom_range(0, 3) == 0);
      step();
      flush = 1'b0;
      chk_state("rnd_idle", m, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
